// File: rtl/ltsm_multi_link_monitor.sv
// Multi-link UCIe LTSM supervisor: sticky progress flags, transition
// counters, a round-robin state-change event stream and a run verdict.
module ltsm_multi_link_monitor #(
    parameter int NUM_LINKS      = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 24,
    parameter int CNT_W          = 8,
    parameter bit STOP_ON_ERROR  = 1'b1,
    localparam int LW = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic                       clear_i,
    input  logic [3*NUM_LINKS-1:0]     link_state_i,
    output logic [NUM_LINKS-1:0]       active_reached_o,
    output logic [NUM_LINKS-1:0]       trainerror_seen_o,
    output logic [NUM_LINKS-1:0]       illegal_state_o,
    output logic [CNT_W*NUM_LINKS-1:0] trans_cnt_o,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [LW-1:0]              evt_link_o,
    output logic [2:0]                 evt_state_o,
    output logic                       evt_overflow_o,
    output logic                       running_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic                       timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    state_e               state_q;
    logic [TO_W-1:0]      timer_q;
    logic                 pass_q, fail_q, to_q;

    logic [2:0]           cur      [NUM_LINKS];
    logic [2:0]           prev_q   [NUM_LINKS];
    logic [CNT_W-1:0]     cnt_q    [NUM_LINKS];
    logic [2:0]           slot_s_q [NUM_LINKS];
    logic [2:0]           slot_s_d [NUM_LINKS];
    logic [NUM_LINKS-1:0] slot_v_q, slot_v_d;
    logic [NUM_LINKS-1:0] act_q, act_d;
    logic [NUM_LINKS-1:0] err_q, err_d;
    logic [NUM_LINKS-1:0] ill_q, ill_d;
    logic [NUM_LINKS-1:0] load;
    logic                 ovf_q, ovf_d;
    logic                 evt_v_q, evt_v_d;
    logic [LW-1:0]        evt_l_q, evt_l_d;
    logic [2:0]           evt_s_q, evt_s_d;
    logic [LW-1:0]        rr_q, rr_d, sel;
    logic                 run, pop, found;

    assign run = (state_q == S_RUN);
    assign pop = evt_v_q & evt_ready_i;

    always_comb begin
        act_d    = act_q;
        err_d    = err_q;
        ill_d    = ill_q;
        slot_v_d = slot_v_q;
        ovf_d    = ovf_q;
        load     = '0;
        for (int k = 0; k < NUM_LINKS; k++) begin
            cur[k]      = link_state_i[3*k +: 3];
            slot_s_d[k] = slot_s_q[k];
            load[k]     = run && (cur[k] != prev_q[k]);
            if (run && cur[k] == 3'b101) act_d[k] = 1'b1;
            if (run && cur[k] == 3'b110) err_d[k] = 1'b1;
            if (run && cur[k] == 3'b111) ill_d[k] = 1'b1;
            if (pop && evt_l_q == LW'(k)) slot_v_d[k] = 1'b0;
            // A reload landing on a popped slot keeps it valid, no loss
            if (load[k]) begin
                if (slot_v_q[k] && !(pop && evt_l_q == LW'(k)))
                    ovf_d = 1'b1;
                slot_v_d[k] = 1'b1;
                slot_s_d[k] = cur[k];
            end
        end
        if (clear_i) begin
            act_d    = '0;
            err_d    = '0;
            ill_d    = '0;
            slot_v_d = '0;
            ovf_d    = 1'b0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (pop)
            rr_d = (int'(evt_l_q) == NUM_LINKS - 1) ? '0 : evt_l_q + LW'(1);
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (!found && slot_v_d[(int'(rr_d) + i) % NUM_LINKS]) begin
                found = 1'b1;
                sel   = LW'((int'(rr_d) + i) % NUM_LINKS);
            end
        end
        // A stalled event keeps its link; its state tracks overwrites
        if (evt_v_q && !evt_ready_i) begin
            evt_v_d = 1'b1;
            evt_l_d = evt_l_q;
            evt_s_d = slot_s_d[evt_l_q];
        end else begin
            evt_v_d = found;
            evt_l_d = found ? sel : '0;
            evt_s_d = found ? slot_s_d[sel] : 3'b000;
        end
        if (clear_i) begin
            rr_d    = '0;
            evt_v_d = 1'b0;
            evt_l_d = '0;
            evt_s_d = 3'b000;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            act_q    <= '0;
            err_q    <= '0;
            ill_q    <= '0;
            slot_v_q <= '0;
            ovf_q    <= 1'b0;
            evt_v_q  <= 1'b0;
            evt_l_q  <= '0;
            evt_s_q  <= 3'b000;
            rr_q     <= '0;
            for (int k = 0; k < NUM_LINKS; k++) begin
                prev_q[k]   <= 3'b000;
                cnt_q[k]    <= '0;
                slot_s_q[k] <= 3'b000;
            end
        end else begin
            act_q    <= act_d;
            err_q    <= err_d;
            ill_q    <= ill_d;
            slot_v_q <= slot_v_d;
            ovf_q    <= ovf_d;
            evt_v_q  <= evt_v_d;
            evt_l_q  <= evt_l_d;
            evt_s_q  <= evt_s_d;
            rr_q     <= rr_d;
            for (int k = 0; k < NUM_LINKS; k++) begin
                prev_q[k]   <= cur[k];
                slot_s_q[k] <= slot_s_d[k];
                if (clear_i)
                    cnt_q[k] <= '0;
                else if (load[k] && cnt_q[k] != '1)
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else if (clear_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (start_i) state_q <= S_RUN;
                end
                S_RUN: begin
                    timer_q <= timer_q + TO_W'(1);
                    if (&act_d) begin
                        state_q <= S_PASS;
                        pass_q  <= 1'b1;
                    end else if (STOP_ON_ERROR && |err_d) begin
                        state_q <= S_FAIL;
                        fail_q  <= 1'b1;
                    end else if (timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= S_FAIL;
                        fail_q  <= 1'b1;
                        to_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        trans_cnt_o = '0;
        for (int k = 0; k < NUM_LINKS; k++)
            trans_cnt_o[CNT_W*k +: CNT_W] = cnt_q[k];
    end

    assign active_reached_o  = act_q;
    assign trainerror_seen_o = err_q;
    assign illegal_state_o   = ill_q;
    assign evt_valid_o       = evt_v_q;
    assign evt_link_o        = evt_l_q;
    assign evt_state_o       = evt_s_q;
    assign evt_overflow_o    = ovf_q;
    assign running_o         = run;
    assign pass_o            = pass_q;
    assign fail_o            = fail_q;
    assign timeout_o         = to_q;

endmodule
